// File: rtl/set_assoc_cache.sv
// Two-way set-associative write-back / write-allocate data cache with per-set LRU.
// Latency: a hit completes one cycle after accept; a miss adds a dirty-line write-back and a line refill.
// Backpressure: ready is low outside IDLE and strobes are dropped; each memory word waits for mem_ack.
module set_assoc_cache #(
  parameter int NUM_SETS       = 8,
  parameter int WORDS_PER_LINE = 4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        access,
  input  logic [31:0] Address,
  input  logic [31:0] Write_Data,
  input  logic        Write_Enable,
  output logic        ready,
  output logic        done,
  output logic [31:0] Data_Out,
  output logic        Hit_Miss,
  output logic [31:0] total_accesses,
  output logic [31:0] total_misses,
  output logic [31:0] total_writebacks,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_ack
);

  localparam int WB = $clog2(WORDS_PER_LINE);
  localparam int IB = $clog2(NUM_SETS);
  localparam int TB = 30 - WB - IB;

  typedef enum logic [2:0] {S_IDLE, S_CMP, S_WB, S_FILL, S_RESP} state_t;

  // Request captured at accept; the byte-lane bits are dropped since accesses are word aligned.
  typedef struct packed {
    logic [29:0] waddr;
    logic [31:0] wdata;
    logic        we;
  } req_t;

  state_t state, state_nxt;
  req_t   req_q;

  logic [1:0][NUM_SETS-1:0] valid_q;
  logic [1:0][NUM_SETS-1:0] dirty_q;
  logic [NUM_SETS-1:0]      lru_q;     // way to replace next in each set
  logic [TB-1:0]            tag_mem  [2][NUM_SETS];
  logic [31:0]              data_mem [2][NUM_SETS][WORDS_PER_LINE];

  logic          way_q;   // way being serviced (hit way or chosen victim)
  logic [WB-1:0] k_q;     // word index within the line during write-back/refill

  logic [WB-1:0] off;
  logic [IB-1:0] idx;
  logic [TB-1:0] tg;
  logic hit0, hit1, hit, hit_way;
  logic victim, victim_dirty;
  logic acc_way, last_word, word_ack, resp_fire, fill_done;

  assign off = req_q.waddr[WB-1:0];
  assign idx = req_q.waddr[WB+IB-1:WB];
  assign tg  = req_q.waddr[29:WB+IB];

  assign ready = (state == S_IDLE);

  // Tag compare, victim selection and per-cycle event decode for the latched request.
  always_comb begin
    hit0         = 1'b0;
    hit1         = 1'b0;
    hit          = 1'b0;
    hit_way      = 1'b0;
    victim       = 1'b0;
    victim_dirty = 1'b0;
    acc_way      = 1'b0;
    last_word    = 1'b0;
    word_ack     = 1'b0;
    resp_fire    = 1'b0;
    fill_done    = 1'b0;

    hit0    = valid_q[0][idx] && (tag_mem[0][idx] == tg);
    hit1    = valid_q[1][idx] && (tag_mem[1][idx] == tg);
    hit     = hit0 || hit1;
    hit_way = !hit0;

    // Fill empty ways first (way 0 before way 1), otherwise follow LRU.
    if (!valid_q[0][idx])      victim = 1'b0;
    else if (!valid_q[1][idx]) victim = 1'b1;
    else                       victim = lru_q[idx];
    victim_dirty = valid_q[victim][idx] && dirty_q[victim][idx];

    last_word = &k_q;
    word_ack  = mem_req && mem_ack;
    resp_fire = ((state == S_CMP) && hit) || (state == S_RESP);
    acc_way   = (state == S_RESP) ? way_q : hit_way;
    fill_done = (state == S_FILL) && word_ack && last_word;
  end

  // Next-state logic: lookup, optional write-back, refill, then respond.
  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: if (access) state_nxt = S_CMP;
      S_CMP: begin
        if (hit)               state_nxt = S_IDLE;
        else if (victim_dirty) state_nxt = S_WB;
        else                   state_nxt = S_FILL;
      end
      S_WB:   if (word_ack && last_word) state_nxt = S_FILL;
      S_FILL: if (word_ack && last_word) state_nxt = S_RESP;
      S_RESP: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Line status, LRU, memory port, response outputs and counters.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      req_q            <= '0;
      valid_q          <= '0;
      dirty_q          <= '0;
      lru_q            <= '0;
      way_q            <= 1'b0;
      k_q              <= '0;
      done             <= 1'b0;
      Hit_Miss         <= 1'b0;
      Data_Out         <= '0;
      mem_req          <= 1'b0;
      mem_we           <= 1'b0;
      mem_addr         <= '0;
      mem_wdata        <= '0;
      total_accesses   <= '0;
      total_misses     <= '0;
      total_writebacks <= '0;
    end else begin
      done <= resp_fire;

      if ((state == S_IDLE) && access) begin
        req_q          <= '{waddr: Address[31:2], wdata: Write_Data, we: Write_Enable};
        total_accesses <= total_accesses + 32'd1;
      end

      if (state == S_CMP) begin
        way_q <= hit ? hit_way : victim;
        k_q   <= '0;
        if (!hit) begin
          total_misses <= total_misses + 32'd1;
          if (victim_dirty) total_writebacks <= total_writebacks + 32'd1;
        end
      end

      // One word per request; mem_req drops for a cycle after every ack.
      if ((state == S_WB) || (state == S_FILL)) begin
        if (!mem_req) begin
          mem_req <= 1'b1;
          mem_we  <= (state == S_WB);
          if (state == S_WB) begin
            mem_addr  <= {tag_mem[way_q][idx], idx, k_q, 2'b00};
            mem_wdata <= data_mem[way_q][idx][k_q];
          end else begin
            mem_addr  <= {tg, idx, k_q, 2'b00};
          end
        end else if (mem_ack) begin
          mem_req <= 1'b0;
          k_q     <= k_q + 1'b1;  // wraps to 0 after the last word
        end
      end

      if (fill_done) begin
        valid_q[way_q][idx] <= 1'b1;
        dirty_q[way_q][idx] <= 1'b0;
      end

      if (resp_fire) begin
        Hit_Miss   <= (state == S_CMP);
        Data_Out   <= req_q.we ? req_q.wdata : data_mem[acc_way][idx][off];
        lru_q[idx] <= ~acc_way;
        if (req_q.we) dirty_q[acc_way][idx] <= 1'b1;
      end
    end
  end

  // Tag and data storage: refill words, new tag on refill completion, store data on response.
  always_ff @(posedge clk) begin
    if ((state == S_FILL) && word_ack) data_mem[way_q][idx][k_q] <= mem_rdata;
    if (fill_done)                     tag_mem[way_q][idx]       <= tg;
    if (resp_fire && req_q.we)         data_mem[acc_way][idx][off] <= req_q.wdata;
  end

endmodule
